// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the Flipper CPU interface bus arbiter.
package cpu_bus_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 32;
    localparam int CPU_STRB_W = 4;

    // Read data returned to a requester whose transfer was forced to complete.
    localparam logic [CPU_DATA_W-1:0] CPU_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

endpackage

// File: rtl/cpu_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    int j;

    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(last_grant) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any_req && req[j]) begin
                any_req = 1'b1;
                winner  = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing the CPU interface bus between NUM_REQ requesters.
// Define CPU_BUS_TIMEOUT_EN to add the stall timeout and the timeout_irq output.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req_read,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*CPU_ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*CPU_DATA_W-1:0] req_write_data,
    input  logic [NUM_REQ*CPU_STRB_W-1:0] req_strobe,
    output logic [NUM_REQ-1:0]           req_wait_request,
    output logic [CPU_DATA_W-1:0]        req_read_data,
    output logic                         CPURead,
    output logic                         CPUWrite,
    output logic [CPU_ADDR_W-1:0]        CPUAddress,
    output logic [CPU_DATA_W-1:0]        CPUWriteData,
    output logic [CPU_STRB_W-1:0]        CPUStrobe,
    input  logic [CPU_DATA_W-1:0]        CPUReadData,
    input  logic                         CPUWaitRequest
`ifdef CPU_BUS_TIMEOUT_EN
    ,
    output logic                         timeout_irq
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("cpu_bus_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("cpu_bus_arbiter: TIMEOUT_CYCLES must be in 2..65536");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic [NUM_REQ-1:0] req_active;

    logic                  g_read, g_write;
    logic [CPU_ADDR_W-1:0] g_addr;
    logic [CPU_DATA_W-1:0] g_wdata;
    logic [CPU_STRB_W-1:0] g_strb;
    logic                  busy, xfer_done, timeout_hit;

    assign req_active = req_read | req_write;
    assign busy       = (state_q == ST_BUSY);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req_active),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_comb begin
        g_read  = 1'b0;
        g_write = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        g_strb  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                g_read  = req_read[i];
                g_write = req_write[i];
                g_addr  = req_address[i*CPU_ADDR_W +: CPU_ADDR_W];
                g_wdata = req_write_data[i*CPU_DATA_W +: CPU_DATA_W];
                g_strb  = req_strobe[i*CPU_STRB_W +: CPU_STRB_W];
            end
        end
    end

    // Downstream is quiet outside BUSY, so reset silences it without a clock edge.
    assign CPUWrite     = busy & g_write;
    assign CPURead      = busy & g_read & ~g_write;
    assign CPUAddress   = busy ? g_addr  : '0;
    assign CPUWriteData = busy ? g_wdata : '0;
    assign CPUStrobe    = busy ? g_strb  : '0;
    assign xfer_done    = (CPURead | CPUWrite) & ~CPUWaitRequest;

`ifdef CPU_BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = '0;
        if (busy) begin
            tmo_cnt_d = CPUWaitRequest ? tmo_cnt_q + 16'd1 : tmo_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit   = busy & (CPURead | CPUWrite) & CPUWaitRequest
                         & (tmo_cnt_q == TIMEOUT_LAST);
    assign timeout_irq   = timeout_hit;
    assign req_read_data = timeout_hit ? CPU_TIMEOUT_DATA : CPUReadData;
`else
    assign timeout_hit   = 1'b0;
    assign req_read_data = CPUReadData;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_wait_request[i] = req_active[i];
            if (busy && grant_q == IDX_W'(i) && (!CPUWaitRequest || timeout_hit)) begin
                req_wait_request[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_BUSY;
                    grant_d      = winner;
                    last_grant_d = winner;
                end
            end
            ST_BUSY: begin
                // A requester withdrawing its command aborts the grant without completion.
                if (!(g_read || g_write) || xfer_done || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
